// File: rtl/jtag_pkg.sv
// JTAG TAP shared types: state encodings, instruction codes and
// the registered strobe bundle driven by tap_controller.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  localparam logic [1:0] EXTEST  = 2'b00;
  localparam logic [1:0] INTEST  = 2'b01;
  localparam logic [1:0] RUNBIST = 2'b10;
  localparam logic [1:0] BYPASS  = 2'b11;

  typedef struct packed {
    logic clockdr;
    logic shiftdr;
    logic updatedr;
    logic clockir;
    logic shiftir;
    logic updateir;
    logic tdo_sel_ir;
    logic tdo_en;
    logic hold;
    logic bistsel;
    logic bist_done;
  } tap_out_t;

  function automatic logic is_ir_col(tap_state_e s);
    return s inside {SEL_IR, CAP_IR, SH_IR, EX1_IR,
                     PAUSE_IR, EX2_IR, UPD_IR};
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// TAP state register and TMS-driven next-state logic.
// Exposes next so the parent can register glitch-free strobes.
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       ck,
  input  logic       rst_n,
  input  logic       tms,
  output tap_state_e state,
  output tap_state_e next
);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state <= TLR;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      TLR:      next = tms ? TLR    : RTI;
      RTI:      next = tms ? SEL_DR : RTI;
      SEL_DR:   next = tms ? SEL_IR : CAP_DR;
      CAP_DR:   next = tms ? EX1_DR : SH_DR;
      SH_DR:    next = tms ? EX1_DR : SH_DR;
      EX1_DR:   next = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: next = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   next = tms ? UPD_DR : SH_DR;
      UPD_DR:   next = tms ? SEL_DR : RTI;
      SEL_IR:   next = tms ? TLR    : CAP_IR;
      CAP_IR:   next = tms ? EX1_IR : SH_IR;
      SH_IR:    next = tms ? EX1_IR : SH_IR;
      EX1_IR:   next = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: next = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   next = tms ? UPD_IR : SH_IR;
      UPD_IR:   next = tms ? SEL_DR : RTI;
    endcase
  end

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: FSM, registered strobe decode and the
// RUNBIST cycle counter.
module tap_controller
  import jtag_pkg::*;
#(
  parameter int unsigned BIST_LEN = 16
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       TMS,
  input  logic [1:0] inst,
  output logic [3:0] state,
  output logic       clockdr,
  output logic       shiftdr,
  output logic       updatedr,
  output logic       clockir,
  output logic       shiftir,
  output logic       updateir,
  output logic       tdo_sel_ir,
  output logic       tdo_en,
  output logic       hold,
  output logic       bistsel,
  output logic       bist_done
);

  localparam logic [7:0] LEN = 8'(BIST_LEN);

  tap_state_e cur;
  tap_state_e nxt;
  logic [7:0] count;
  logic [7:0] count_d;
  tap_out_t   out_q;
  tap_out_t   out_d;

  tap_fsm u_fsm (
    .ck    (ck),
    .rst_n (rst_n),
    .tms   (TMS),
    .state (cur),
    .next  (nxt)
  );

  // bistsel is the registered increment condition, so the counter
  // steps exactly on the cycles bistsel is seen high.
  always_comb begin
    count_d = count;
    if (nxt == TLR || nxt == UPD_IR) count_d = '0;
    else if (out_q.bistsel)          count_d = count + 8'd1;
  end

  always_comb begin
    out_d            = '0;
    out_d.clockdr    = nxt inside {CAP_DR, SH_DR};
    out_d.shiftdr    = nxt == SH_DR;
    out_d.updatedr   = nxt == UPD_DR;
    out_d.clockir    = nxt inside {CAP_IR, SH_IR};
    out_d.shiftir    = nxt == SH_IR;
    out_d.updateir   = nxt == UPD_IR;
    out_d.tdo_sel_ir = is_ir_col(nxt);
    out_d.tdo_en     = nxt inside {SH_DR, SH_IR};
    out_d.hold       = (inst == EXTEST || inst == INTEST)
                       && nxt != TLR;
    out_d.bistsel    = nxt == RTI && inst == RUNBIST
                       && count_d < LEN;
    out_d.bist_done  = count_d == LEN;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      out_q <= '0;
    end else begin
      count <= count_d;
      out_q <= out_d;
    end
  end

  assign state      = cur;
  assign clockdr    = out_q.clockdr;
  assign shiftdr    = out_q.shiftdr;
  assign updatedr   = out_q.updatedr;
  assign clockir    = out_q.clockir;
  assign shiftir    = out_q.shiftir;
  assign updateir   = out_q.updateir;
  assign tdo_sel_ir = out_q.tdo_sel_ir;
  assign tdo_en     = out_q.tdo_en;
  assign hold       = out_q.hold;
  assign bistsel    = out_q.bistsel;
  assign bist_done  = out_q.bist_done;

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: directed TAP walks plus random TMS/inst
// traffic, each cycle compared against a table-driven TAP model.
module tb_tap_controller;

  localparam int LEN = 16;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       TMS = 1'b1;
  logic [1:0] inst = 2'b11;
  logic [3:0] state;
  logic clockdr, shiftdr, updatedr;
  logic clockir, shiftir, updateir;
  logic tdo_sel_ir, tdo_en, hold, bistsel, bist_done;
  logic [10:0] dut_vec;

  tap_controller #(.BIST_LEN(LEN)) dut (
    .ck         (ck),
    .rst_n      (rst_n),
    .TMS        (TMS),
    .inst       (inst),
    .state      (state),
    .clockdr    (clockdr),
    .shiftdr    (shiftdr),
    .updatedr   (updatedr),
    .clockir    (clockir),
    .shiftir    (shiftir),
    .updateir   (updateir),
    .tdo_sel_ir (tdo_sel_ir),
    .tdo_en     (tdo_en),
    .hold       (hold),
    .bistsel    (bistsel),
    .bist_done  (bist_done)
  );

  assign dut_vec = {clockdr, shiftdr, updatedr, clockir, shiftir,
                    updateir, tdo_sel_ir, tdo_en, hold, bistsel,
                    bist_done};

  always #5 ck = ~ck;

  int n_tests = 0;
  int n_fail = 0;
  int nx0[16];
  int nx1[16];
  int m_st;
  int m_cnt;
  int m_inst;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_bsel();
    return m_st == 12 && m_inst == 2 && m_cnt < LEN;
  endfunction

  function automatic logic [10:0] exp_vec();
    bit ir;
    ir = m_st inside {4, 14, 10, 9, 11, 8, 13};
    return {m_st == 6 || m_st == 2, m_st == 2, m_st == 5,
            m_st == 14 || m_st == 10, m_st == 10, m_st == 13,
            ir, m_st == 2 || m_st == 10,
            m_inst < 2 && m_st != 15, m_bsel(), m_cnt == LEN};
  endfunction

  task automatic tick(input bit t, input logic [1:0] i);
    bit inc;
    int ns;
    TMS = t;
    inst = i;
    inc = m_bsel();
    @(posedge ck);
    ns = t ? nx1[m_st] : nx0[m_st];
    m_cnt = (ns == 15 || ns == 13) ? 0 : m_cnt + int'(inc);
    m_st = ns;
    m_inst = int'(i);
    @(negedge ck);
    check("state", int'(state), m_st);
    check("outs", int'(dut_vec), int'(exp_vec()));
  endtask

  task automatic walk_to(input int target);
    int k = 0;
    while (m_st != target && k < 400) begin
      tick(1'($urandom_range(0, 1)), 2'b11);
      k++;
    end
    if (k >= 400) check("reach", int'(state), target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cd, sd, ud, sel;
    bit s31[9];
    logic [1:0] cur_inst;
    s31 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    nx0[15] = 12; nx1[15] = 15;
    nx0[12] = 12; nx1[12] = 7;
    nx0[7]  = 6;  nx1[7]  = 4;
    nx0[4]  = 14; nx1[4]  = 15;
    nx0[6]  = 2;  nx1[6]  = 1;
    nx0[2]  = 2;  nx1[2]  = 1;
    nx0[1]  = 3;  nx1[1]  = 5;
    nx0[3]  = 3;  nx1[3]  = 0;
    nx0[0]  = 2;  nx1[0]  = 5;
    nx0[5]  = 12; nx1[5]  = 7;
    nx0[14] = 10; nx1[14] = 9;
    nx0[10] = 10; nx1[10] = 9;
    nx0[9]  = 11; nx1[9]  = 13;
    nx0[11] = 11; nx1[11] = 8;
    nx0[8]  = 10; nx1[8]  = 13;
    nx0[13] = 12; nx1[13] = 7;
    m_st = 15;
    m_cnt = 0;
    m_inst = 3;

    repeat (2) @(negedge ck);
    check("rst_state", int'(state), 15);
    check("rst_outs", int'(dut_vec), 0);
    rst_n = 1'b1;
    tick(1'b1, 2'b11);

    for (int s = 0; s < 16; s++) begin
      walk_to(s);
      repeat (5) tick(1'b1, 2'b11);
      check("tlr5", int'(state), 15);
    end

    cd = 0; sd = 0; ud = 0;
    for (int i = 0; i < 9; i++) begin
      tick(s31[i], 2'b11);
      cd += int'(clockdr);
      sd += int'(shiftdr);
      ud += int'(updatedr);
    end
    check("clockdr_cyc", cd, 4);
    check("shiftdr_cyc", sd, 3);
    check("updatedr_cyc", ud, 1);
    check("dr_end", int'(state), 12);

    sel = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 2'b10);
      sel += int'(bistsel);
    end
    check("bistsel_cyc", sel, 16);
    check("bist_done", int'(bist_done), 1);
    tick(1'b1, 2'b10);
    tick(1'b0, 2'b10);
    tick(1'b1, 2'b10);
    tick(1'b1, 2'b10);
    tick(1'b0, 2'b10);
    check("done_kept", int'(bist_done), 1);
    check("bistsel_sat", int'(bistsel), 0);

    sel = 0;
    tick(1'b1, 2'b11);
    tick(1'b1, 2'b11); sel += int'(tdo_sel_ir);
    tick(1'b0, 2'b11); sel += int'(tdo_sel_ir);
    tick(1'b0, 2'b11); sel += int'(tdo_sel_ir);
    tick(1'b1, 2'b11); sel += int'(tdo_sel_ir);
    check("done_pre_updir", int'(bist_done), 1);
    tick(1'b1, 2'b01); sel += int'(tdo_sel_ir);
    check("ir_sel_cyc", sel, 5);
    check("updir_clear", int'(bist_done), 0);
    tick(1'b0, 2'b01);
    check("hold_new", int'(hold), 1);

    tick(1'b1, 2'b11);
    tick(1'b0, 2'b11);
    tick(1'b0, 2'b11);
    check("in_shdr", int'(state), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", int'(state), 15);
    check("async_outs", int'(dut_vec), 0);
    m_st = 15;
    m_cnt = 0;
    @(negedge ck);
    rst_n = 1'b1;
    ud = 0;
    repeat (3) begin
      tick(1'b1, 2'b11);
      ud += int'(updatedr);
    end
    tick(1'b0, 2'b11);
    ud += int'(updatedr);
    check("no_upd", ud, 0);

    cur_inst = 2'b10;
    repeat (1500) begin
      if ($urandom_range(0, 15) == 0) cur_inst = 2'($urandom);
      tick($urandom_range(0, 9) < 3, cur_inst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 Parameter BIST_LEN, default 16: number of ck cycles a RUNBIST run lasts; range 1..255.
REQ-002 ck  input  1  the single system/test clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 TMS  input  1  test mode select, sampled on rising ck.
REQ-005 inst  input  2  current instruction from the IR update stage: 00 EXTEST, 01 INTEST, 10 RUNBIST, 11 BYPASS.
REQ-006 state  output  4  current TAP state encoding.
REQ-007 clockdr  output  1  clock enable to DR chain capture flops, high in Capture-DR and Shift-DR.
REQ-008 shiftdr  output  1  DR shift/load select, high in Shift-DR only.
REQ-009 updatedr  output  1  DR update enable, high in Update-DR only.
REQ-010 clockir, shiftir, updateir  output  1 each  IR equivalents of REQ-007..009 (Capture-IR/Shift-IR, Shift-IR, Update-IR).
REQ-011 tdo_sel_ir  output  1  TDO mux select: 1 = IR chain, 0 = DR chain; high in all IR-column states.
REQ-012 tdo_en  output  1  TDO drive enable, high in Shift-DR or Shift-IR.
REQ-013 hold  output  1  test-data-out select to scan cells, high when inst is EXTEST or INTEST and state is not Test-Logic-Reset.
REQ-014 bistsel  output  1  BIST/LFSR mode select to scan cells.
REQ-015 bist_done  output  1  RUNBIST run complete.

Function
REQ-016 The FSM SHALL implement the 16 IEEE 1149.1 states, with the next state decided only by TMS at each rising ck.
REQ-017 Transitions (TMS=0 / TMS=1): TLR->RTI/TLR; RTI->RTI/SelDR; SelDR->CapDR/SelIR; SelIR->CapIR/TLR; CapX->ShX/Ex1X; ShX->ShX/Ex1X; Ex1X->PauseX/UpdX; PauseX->PauseX/Ex2X; Ex2X->ShX/UpdX; UpdX->RTI/SelDR (X = DR or IR).
REQ-018 Five consecutive TMS=1 cycles SHALL reach TLR from every state.
REQ-019 All outputs SHALL be registered, computed from next state, so each strobe is valid during exactly the cycles the FSM is in its decoding state, with no glitches.
REQ-020 The BIST counter is 8 bits. It SHALL increment once per ck while state=RTI, inst=10, and count<BIST_LEN. It saturates at BIST_LEN.
REQ-021 bistsel SHALL be high exactly while the REQ-020 increment condition holds.
REQ-022 bist_done SHALL be high whenever count==BIST_LEN, and is held until the counter clears.
REQ-023 The counter SHALL clear to 0 in TLR and on Update-IR. Leaving RTI pauses counting and retains the count.
REQ-024 If inst changes while the FSM is outside Update-IR, the counter SHALL NOT clear. hold and bistsel SHALL follow the new inst on the next cycle.

Reset
REQ-025 rst_n low SHALL force state=TLR (4'hF) and count=0 immediately, without waiting for ck.
REQ-026 During and after reset, until the first transition: clockdr, shiftdr, updatedr, clockir, shiftir, updateir, tdo_en, hold, bistsel and bist_done SHALL all be 0, and tdo_sel_ir SHALL be 0.
REQ-027 Reset asserted mid-shift SHALL abort the shift; no update strobe is emitted.

Structure
REQ-028 A shared package jtag_pkg SHALL hold: the state typedef with encodings TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D; and the instruction constants EXTEST/INTEST/RUNBIST/BYPASS.
REQ-029 A single sub-module, tap_fsm, SHALL hold the state register and next-state logic. The output decode and BIST counter SHALL remain in tap_controller.

Verification
REQ-030 Release reset, drive TMS=1 for 5 cycles from each of the 16 states -> state=F after the 5th edge.
REQ-031 From TLR, drive TMS 0,1,0,0,0,0,1,1,0 -> path RTI, SelDR, CapDR, ShDR x3, Ex1DR, UpdDR, RTI. Expect clockdr high for 4 cycles, shiftdr high for 3 cycles, and updatedr high for exactly 1 cycle.
REQ-032 With inst=10 and BIST_LEN=16, hold RTI for 20 cycles -> bistsel high for 16 cycles, then bist_done=1 with count=16. Visit SelDR and return -> bist_done remains 1.
REQ-033 Run an IR scan to Update-IR with inst changing 11->01 -> counter cleared, hold=1 from the next cycle, and tdo_sel_ir high throughout SelIR..UpdIR.
REQ-034 Assert rst_n low while in ShDR mid-cycle -> state=F immediately, all strobes 0, and no updatedr pulse afterwards.
